sdram_read_sched: RTL
=====================

SDRAM_READ_SCHED -- requirements
Module: sdram_read_sched

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  ADDR_W, 24, SDRAM word address width
  BURST_LEN, 8, words per read burst (power of 2, at most 32)
  FIFO_DEPTH, 64, read-FIFO capacity in words
REQ-002 Ports SHALL be (name, direction, width, meaning); clock is single-clock, reset is asynchronous active-low:
  clock       in   1       sole clock, rising edge
  aclr_n      in   1       asynchronous active-low reset
  start       in   1       pulse; latch base/end, begin refill
  stop        in   1       pulse; abort refill
  base_addr   in   ADDR_W  first burst address
  end_addr    in   ADDR_W  exclusive end address
  rd_req      out  1       burst read request to SDRAM controller
  rd_addr     out  ADDR_W  burst start address
  rd_ack      in   1       request accepted
  rd_valid    in   1       returned data beat
  rd_data     in   16      returned data
  fifo_wrreq  out  1       read-FIFO write strobe
  fifo_data   out  16      read-FIFO write data
  fifo_usedw  in   6       read-FIFO fill level
  fifo_full   in   1       read-FIFO full
  busy        out  1       high in any state but IDLE
  done        out  1       one-cycle pulse at end of range
  overrun     out  1       sticky: beat arrived while FIFO full

Function
REQ-003 FSM states SHALL be IDLE, CHECK, REQ, DATA, DRAIN, FLUSH.
REQ-004 IDLE->CHECK SHALL occur on start with stop low; base_addr and end_addr are latched, and the address counter is set to base_addr.
REQ-005 In CHECK, if the 7-bit sum fifo_usedw+BURST_LEN <= FIFO_DEPTH, the FSM SHALL go to REQ; otherwise it remains in CHECK.
REQ-006 In REQ, rd_req SHALL be high with rd_addr equal to the counter, held stable until rd_ack; on rd_ack the FSM SHALL go to DATA.
REQ-007 In DATA, each rd_valid beat SHALL be registered: fifo_data=rd_data and fifo_wrreq=1 exactly one cycle later, giving latency 1.
REQ-008 After BURST_LEN beats, the counter SHALL add BURST_LEN and the FSM SHALL go to DRAIN for exactly one cycle so that fifo_usedw reflects the final write.
REQ-009 From DRAIN: if counter < end_addr, go to CHECK; otherwise pulse done for one cycle and go to IDLE, unless REQ-019 applies.
REQ-010 A rd_valid beat received outside DATA/FLUSH SHALL be ignored.
REQ-011 rd_valid while fifo_full=1 SHALL drop the write and set overrun; overrun clears only on reset or start.
REQ-012 stop in CHECK or DRAIN SHALL go to IDLE on the next edge, with no done pulse.
REQ-013 stop in REQ SHALL keep rd_req high until rd_ack, then go to FLUSH.
REQ-014 stop in DATA SHALL go to FLUSH and keep the current beat count.
REQ-015 FLUSH SHALL count the remaining beats of the burst with fifo_wrreq held at 0, then go to IDLE with no done pulse.
REQ-016 start while busy SHALL be ignored; if start and stop arrive together, stop SHALL win.
REQ-017 Address arithmetic SHALL be modulo 2^ADDR_W; if end_addr <= base_addr at start, the FSM SHALL pulse done and return to IDLE without any request.

Reset
REQ-018 While aclr_n is low: state=IDLE; rd_req, fifo_wrreq, busy, done and overrun are 0; rd_addr, fifo_data, the counter and the beat count are 0. Reset mid-burst SHALL abandon the burst immediately.

Configuration
REQ-019 Macro SDRAM_READ_SCHED_WRAP_EN:
  defined: at the end condition of REQ-009, the counter reloads the latched base_addr, done pulses, and the FSM goes to CHECK (continuous loop until stop).
  undefined: behaviour is exactly as in REQ-009 (single pass).

Verification
REQ-020 base=0x000100, end=0x000120, usedw=0, rd_ack 1 cycle after rd_req, 8 beats each -> 4 requests at 0x100/0x108/0x110/0x118, 32 fifo_wrreq cycles, one done pulse, busy falls.
REQ-021 usedw=57 held -> FSM stays in CHECK with rd_req=0; usedw drops to 56 -> rd_req asserts within 2 cycles.
REQ-022 stop during beat 3 of burst 2 -> beats 4-8 are not written, FSM reaches IDLE after beat 8, done=0, total writes=11.
REQ-023 rd_valid with fifo_full=1 on beat 5 -> that write is suppressed, overrun=1 persists until the next start.
REQ-024 With WRAP_EN, base=0x40, end=0x50 -> address sequence 0x40, 0x48, 0x40, 0x48 ..., done pulses after every second burst; without WRAP_EN, exactly 2 bursts.
REQ-025 aclr_n low during REQ -> rd_req drops asynchronously, all outputs are 0, and after release the FSM is in IDLE until the next start.

Source files
------------

// File: rtl/sdram_read_sched.sv
// sdram_read_sched: walks an SDRAM address range and issues burst reads
// into a read FIFO. A request goes out only when the FIFO has room for a
// whole burst. The returned beats are registered into the FIFO write port.
// Optional build macro SDRAM_READ_SCHED_WRAP_EN: when the range is
// exhausted, reload the base address and keep looping until stop.
module sdram_read_sched #(
    parameter int ADDR_W     = 24,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic              clock,
    input  logic              aclr_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [15:0]       rd_data,
    output logic              fifo_wrreq,
    output logic [15:0]       fifo_data,
    input  logic [5:0]        fifo_usedw,
    input  logic              fifo_full,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int                BW        = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [6:0]        BURST7    = 7'(BURST_LEN);
    localparam logic [6:0]        DEPTH7    = 7'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_DATA,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W-1:0] end_q,   end_d;
    logic [BW-1:0]     beat_q,  beat_d;
    logic              stop_q,  stop_d;
    logic              wr_q,    wr_d;
    logic [15:0]       data_q,  data_d;
    logic              done_q,  done_d;
    logic              ovr_q,   ovr_d;
`ifdef SDRAM_READ_SCHED_WRAP_EN
    logic [ADDR_W-1:0] base_q,  base_d;
`endif

    // Room check: FIFO must be able to absorb a full burst on top of its
    // current fill level.
    logic [6:0] fill_sum;
    logic       last_beat;
    assign fill_sum  = {1'b0, fifo_usedw} + BURST7;
    assign last_beat = (beat_q == LAST_BEAT);

    // Next-state and datapath decode for the scheduler FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        beat_d  = beat_q;
        stop_d  = stop_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
`ifdef SDRAM_READ_SCHED_WRAP_EN
        base_d  = base_q;
`endif
        case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                // stop beats start when both arrive together
                if (start && !stop) begin
`ifdef SDRAM_READ_SCHED_WRAP_EN
                    base_d = base_addr;
`endif
                    end_d  = end_addr;
                    addr_d = base_addr;
                    beat_d = '0;
                    ovr_d  = 1'b0;
                    // An empty or inverted range finishes without a request.
                    if (end_addr > base_addr) begin
                        state_d = S_CHECK;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (fill_sum <= DEPTH7) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A stop here is remembered; the controller must still see
                // the request through to its acknowledge.
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (rd_ack) begin
                    beat_d  = '0;
                    stop_d  = 1'b0;
                    state_d = (stop || stop_q) ? S_FLUSH : S_DATA;
                end
            end
            S_DATA: begin
                if (rd_valid) begin
                    if (fifo_full) begin
                        ovr_d = 1'b1;
                    end else begin
                        wr_d   = 1'b1;
                        data_d = rd_data;
                    end
                    if (last_beat) begin
                        beat_d  = '0;
                        addr_d  = addr_q + BURST_A;
                        state_d = stop ? S_IDLE : S_DRAIN;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
                // The beat arriving with stop is still written; the rest of
                // the burst is discarded in FLUSH.
                if (stop && !(rd_valid && last_beat)) begin
                    state_d = S_FLUSH;
                end
            end
            S_DRAIN: begin
                // One idle cycle lets fifo_usedw catch up with the last write.
                if (stop) begin
                    state_d = S_IDLE;
                end else if (addr_q < end_q) begin
                    state_d = S_CHECK;
                end else begin
                    done_d = 1'b1;
`ifdef SDRAM_READ_SCHED_WRAP_EN
                    addr_d  = base_q;
                    state_d = S_CHECK;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_FLUSH: begin
                if (rd_valid) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any burst at once.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            beat_q  <= '0;
            stop_q  <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            beat_q  <= beat_d;
            stop_q  <= stop_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SDRAM_READ_SCHED_WRAP_EN
    // Latched base address used to restart the loop.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end
`endif

    assign rd_req     = (state_q == S_REQ);
    assign rd_addr    = addr_q;
    assign fifo_wrreq = wr_q;
    assign fifo_data  = data_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign overrun    = ovr_q;

endmodule
